// File: rtl/serial_comm_tx_pkg.sv
// Constants shared by the serial link transmitter and the serialCOMM receiver:
// FSM encoding, colour/size codes and frame geometry.
package serial_comm_tx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam logic [3:0] COLOR_RED    = 4'b0000;
   localparam logic [3:0] COLOR_ORANGE = 4'b0001;
   localparam logic [3:0] COLOR_YELLOW = 4'b0010;
   localparam logic [3:0] COLOR_GREEN  = 4'b0011;
   localparam logic [3:0] COLOR_BLUE   = 4'b0100;
   localparam logic [3:0] COLOR_BROWN  = 4'b0101;

   localparam logic [3:0] SIZE_AIR  = 4'b0000;
   localparam logic [3:0] SIZE_SEA  = 4'b0001;
   localparam logic [3:0] SIZE_RAIL = 4'b0010;

   localparam int FRAME_BITS  = 8;
   localparam int SYNC_HALVES = 2;
   localparam int GAP_HALVES  = 2;

endpackage

// File: rtl/serial_comm_tx_bit_timer.sv
// Half-period counter: tick marks the last cycle of each TCLK half-period,
// near marks the cycle before it (used to end the gap one cycle early).
module tx_bit_timer #(
   parameter int HALF_PERIOD = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick,
   output logic near
);

   localparam int CW = $clog2(HALF_PERIOD + 1);
   localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] PRE  = (HALF_PERIOD > 1) ? CW'(HALF_PERIOD - 2) : '0;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!en || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = en && (cnt == LAST);
   assign near = en && (HALF_PERIOD > 1) && (cnt == PRE);

endmodule

// File: rtl/serial_comm_tx.sv
// Serial frame transmitter: SYNC (TRESET high), 8 data bits MSB first on a
// TCLK whose rising edge samples TDATA, then a quiet gap ending in DONE.
module serial_comm_tx
   import serial_comm_tx_pkg::*;
#(
   parameter int HALF_PERIOD = 50
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [3:0] COLOR,
   input  logic [3:0] SIZE,
   input  logic       SEND,
   output logic       READY,
   output logic       DONE,
   output logic       TCLK,
   output logic       TDATA,
   output logic       TRESET
);

   logic [1:0] state;
   logic [7:0] sreg;
   logic [2:0] bit_cnt;
   logic [1:0] halves;
   logic       tick, near, gap_end;

   tx_bit_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
      .clk   (CLK),
      .rst_n (RESET_N),
      .en    (state != ST_IDLE),
      .tick  (tick),
      .near  (near)
   );

   // DONE must land in the gap's last cycle, so the gap ends one cycle before
   // its final tick; with a 1-cycle half-period that is the first gap cycle.
   assign gap_end = (HALF_PERIOD == 1) ? (tick && halves == 2'(GAP_HALVES - 2))
                                       : (near && halves == 2'(GAP_HALVES - 1));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= ST_IDLE;
         READY   <= 1'b1;
         DONE    <= 1'b0;
         TCLK    <= 1'b0;
         TDATA   <= 1'b0;
         TRESET  <= 1'b0;
         sreg    <= '0;
         bit_cnt <= '0;
         halves  <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: if (SEND) begin
               sreg    <= {SIZE, COLOR};
               bit_cnt <= '0;
               halves  <= '0;
               READY   <= 1'b0;
               TRESET  <= 1'b1;
               TCLK    <= 1'b0;
               TDATA   <= 1'b0;
               state   <= ST_SYNC;
            end
            ST_SYNC: if (tick) begin
               if (halves == 2'(SYNC_HALVES - 1)) begin
                  halves <= '0;
                  TRESET <= 1'b0;
                  TDATA  <= sreg[7];
                  state  <= ST_SHIFT;
               end else
                  halves <= halves + 2'd1;
            end
            ST_SHIFT: if (tick) begin
               if (halves == 2'd0) begin
                  TCLK   <= 1'b1;
                  halves <= 2'd1;
               end else begin
                  TCLK   <= 1'b0;
                  halves <= '0;
                  if (bit_cnt == 3'(FRAME_BITS - 1)) begin
                     TDATA <= 1'b0;
                     state <= ST_GAP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     sreg    <= {sreg[6:0], 1'b0};
                     TDATA   <= sreg[6];
                  end
               end
            end
            ST_GAP: begin
               if (gap_end) begin
                  halves <= '0;
                  READY  <= 1'b1;
                  DONE   <= 1'b1;
                  state  <= ST_IDLE;
               end else if (tick)
                  halves <= halves + 2'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/serial_comm_tx.md
SERIAL_COMM_TX -- requirements
Module: serial_comm_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 50, meaning CLK cycles per TCLK half-period; legal range 1..1023.
REQ-002 SHALL have port CLK, input, 1, system clock (100 MHz); the block uses one clock.
REQ-003 SHALL have port RESET_N, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port COLOR, input, 4, colour code: RED 0000, ORANGE 0001, YELLOW 0010, GREEN 0011, BLUE 0100, BROWN 0101.
REQ-005 SHALL have port SIZE, input, 4, size code: AIR 0000, SEA 0001, RAIL 0010.
REQ-006 SHALL have port SEND, input, 1, request strobe; it is sampled every CLK cycle.
REQ-007 SHALL have port READY, output, 1, high when a SEND will be accepted.
REQ-008 SHALL have port DONE, output, 1, one-cycle pulse at end of frame.
REQ-009 SHALL have port TCLK, output, 1, serial clock to the receiver's RCLK.
REQ-010 SHALL have port TDATA, output, 1, serial data to the receiver's RDATA.
REQ-011 SHALL have port TRESET, output, 1, frame-sync/clear to the receiver's RESET; active high.

Function
REQ-012 SHALL implement states IDLE, SYNC, SHIFT, GAP.
REQ-013 SHALL register all outputs, with no combinational path from any input to any output.
REQ-014 SHALL accept SEND only when READY=1, latching {SIZE,COLOR} into an 8-bit shift register and entering SYNC on the next cycle.
REQ-015 SHALL ignore SEND while READY=0, with no queuing and no effect on the frame in flight.
REQ-016 SHALL, in SYNC, drive TRESET=1, TCLK=0 and TDATA=0 for 2*HALF_PERIOD cycles, then enter SHIFT.
REQ-017 SHALL, in SHIFT, send 8 bits MSB first (SIZE[3] first, COLOR[0] last).
REQ-018 SHALL time each bit as TDATA updated at bit start, TCLK low for HALF_PERIOD cycles, then TCLK high for HALF_PERIOD cycles; the receiver samples on the TCLK rising edge.
REQ-019 SHALL keep TDATA stable throughout the TCLK high phase and across the rising edge.
REQ-020 SHALL, after bit 8's high phase, drive TCLK=0, TDATA=0, TRESET=0 and enter GAP for 2*HALF_PERIOD cycles.
REQ-021 SHALL, at GAP expiry, return to IDLE, pulse DONE for exactly 1 cycle and assert READY in that same cycle.
REQ-022 SHALL make frame length exactly 20*HALF_PERIOD cycles, measured from the cycle after SEND acceptance to DONE inclusive.
REQ-023 SHALL accept a SEND in the DONE cycle, giving back-to-back frames with no extra idle cycle.
REQ-024 SHALL transmit out-of-range codes (COLOR>0101, SIZE>0010) unchanged; validation belongs to the receiver.
REQ-025 SHALL use a half-period counter of ceil(log2(HALF_PERIOD+1)) bits that wraps to 0 at HALF_PERIOD-1, and a 3-bit bit counter that saturates at 7.
REQ-026 SHALL produce exactly 1-cycle TCLK phases and the same 20-cycle frame when HALF_PERIOD=1.
REQ-027 SHALL hold TCLK=0, TDATA=0, TRESET=0 in IDLE.

Reset
REQ-028 SHALL, while RESET_N=0, force state=IDLE, READY=1, DONE=0, TCLK=0, TDATA=0, TRESET=0, and clear all counters and the shift register.
REQ-029 SHALL, on reset mid-frame, abort the frame immediately with no DONE; the next frame's SYNC phase clears the receiver's partial data.
REQ-030 SHALL accept SEND on the first rising CLK edge after RESET_N deasserts.

Structure
REQ-031 SHALL place the state encoding, the COLOR and SIZE code constants, FRAME_BITS=8, SYNC_HALVES=2 and GAP_HALVES=2 in a shared package, so that serialCOMM and serial_comm_tx share the same constants.
REQ-032 SHALL split out one sub-module, tx_bit_timer, a half-period counter that emits a one-cycle tick at each half-period boundary, enabled by the FSM.

Verification
REQ-033 SHALL cover: HALF_PERIOD=4, SEND with COLOR=GREEN 0011, SIZE=SEA 0001 -> TRESET high for 8 cycles, TCLK rising edges sample 0,0,0,1,0,0,1,1, DONE at cycle 80.
REQ-034 SHALL cover: SEND pulsed again at cycles 10 and 40 of a frame -> no change to the waveform, READY=0, exactly one DONE.
REQ-035 SHALL cover: SEND held high continuously with BLUE/RAIL -> frames back-to-back every 80 cycles, each starting with TRESET the cycle after DONE.
REQ-036 SHALL cover: RESET_N low for 3 cycles at cycle 30 -> all outputs 0, READY=1 asynchronously, no DONE; a subsequent frame is correct.
REQ-037 SHALL cover: HALF_PERIOD=1, COLOR=BROWN, SIZE=AIR -> 20-cycle frame, bit stream 0000_0101.
REQ-038 SHALL cover: loopback of TCLK/TDATA/TRESET into serialCOMM for all 18 valid COLOR/SIZE pairs -> the receiver's COLOR and SIZE match the sent values after each DONE.
